// File: rtl/taxi_eth_tx_arb_pkg.sv
// Shared types and round-robin helper for the MAC TX frame arbiter.
// Pure combinational helpers, no state.
package taxi_eth_tx_arb_pkg;

    localparam int RR_MAX_PORTS = 16;
    localparam int RR_IDX_W     = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_sel_t;

    // First set request strictly after ptr, wrapping at ports; ptr itself is checked last.
    function automatic rr_sel_t rr_next_grant(
        input logic [RR_MAX_PORTS-1:0] req,
        input logic [RR_IDX_W-1:0]     ptr,
        input int                      ports
    );
        rr_sel_t res;
        int      cand;
        res = '0;
        for (int k = 1; k <= RR_MAX_PORTS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= ports) begin
                cand = cand - ports;
            end
            if ((k <= ports) && !res.found && req[cand[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/taxi_rr_arb_sel.sv
// Combinational round-robin priority selector: searches upward from ptr_i+1 modulo N.
// Zero latency, no flow control.
module taxi_rr_arb_sel
    import taxi_eth_tx_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [RR_MAX_PORTS-1:0] req_ext;
    rr_sel_t                 sel;
    logic                    sel_unused;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
        sel            = rr_next_grant(req_ext, RR_IDX_W'(ptr_i), N);
    end

    assign idx_o      = sel.idx[W-1:0];
    assign found_o    = sel.found;
    assign sel_unused = ^sel.idx;

endmodule

// File: rtl/taxi_eth_tx_frame_arb.sv
// Frame-granular round-robin mux of PORTS AXI-S sources onto one MAC TX stream, source index prefixed to tid.
// One idle arbitration cycle per frame, then zero-latency passthrough; completions demuxed back by tag with zero latency.
module taxi_eth_tx_frame_arb
    import taxi_eth_tx_arb_pkg::*;
#(
    parameter int PORTS     = 4,
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = DATA_W/8,
    parameter int USER_W    = 1,
    parameter int SRC_TAG_W = 12,
    parameter int PORT_W    = $clog2(PORTS),
    parameter int MAC_TAG_W = SRC_TAG_W + PORT_W,
    parameter int CPL_W     = 96
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [PORTS*DATA_W-1:0]    s_tdata,
    input  logic [PORTS*KEEP_W-1:0]    s_tkeep,
    input  logic [PORTS-1:0]           s_tvalid,
    output logic [PORTS-1:0]           s_tready,
    input  logic [PORTS-1:0]           s_tlast,
    input  logic [PORTS*USER_W-1:0]    s_tuser,
    input  logic [PORTS*SRC_TAG_W-1:0] s_tid,

    output logic [DATA_W-1:0]          m_tdata,
    output logic [KEEP_W-1:0]          m_tkeep,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [USER_W-1:0]          m_tuser,
    output logic [MAC_TAG_W-1:0]       m_tid,

    input  logic [CPL_W-1:0]           s_cpl_tdata,
    input  logic [MAC_TAG_W-1:0]       s_cpl_tid,
    input  logic                       s_cpl_tvalid,
    output logic                       s_cpl_tready,

    output logic [CPL_W-1:0]           m_cpl_tdata,
    output logic [SRC_TAG_W-1:0]       m_cpl_tid,
    output logic [PORTS-1:0]           m_cpl_tvalid,
    input  logic [PORTS-1:0]           m_cpl_tready,

    input  logic [PORTS-1:0]           cfg_port_enable,
    output logic [PORTS-1:0]           stat_grant,
    output logic                       stat_busy
);

    arb_state_t        state_q;
    logic [PORT_W-1:0] grant_q;
    logic [PORT_W-1:0] rr_ptr_q;
    logic [PORTS-1:0]  stat_grant_q;

    logic [PORTS-1:0]  req;
    logic [PORT_W-1:0] sel_idx;
    logic              sel_found;
    logic              active;
    logic              frame_end;

    logic                 g_vld;
    logic                 g_last;
    logic [DATA_W-1:0]    g_dat;
    logic [KEEP_W-1:0]    g_keep;
    logic [USER_W-1:0]    g_user;
    logic [SRC_TAG_W-1:0] g_tid;

    logic [PORT_W-1:0]    cpl_port;
    logic                 cpl_rdy;

    assign req = s_tvalid & cfg_port_enable;

    taxi_rr_arb_sel #(
        .N (PORTS),
        .W (PORT_W)
    ) u_sel (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    // Reset gates every handshake immediately so an aborted frame cannot leak a beat.
    assign active = (state_q == ST_ACTIVE) && !rst;

    always_comb begin
        g_vld  = 1'b0;
        g_last = 1'b0;
        g_dat  = '0;
        g_keep = '0;
        g_user = '0;
        g_tid  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_q == PORT_W'(i)) begin
                g_vld  = s_tvalid[i];
                g_last = s_tlast[i];
                g_dat  = s_tdata[i*DATA_W +: DATA_W];
                g_keep = s_tkeep[i*KEEP_W +: KEEP_W];
                g_user = s_tuser[i*USER_W +: USER_W];
                g_tid  = s_tid[i*SRC_TAG_W +: SRC_TAG_W];
            end
        end
    end

    always_comb begin
        s_tready = '0;
        if (active) begin
            for (int i = 0; i < PORTS; i++) begin
                s_tready[i] = (grant_q == PORT_W'(i)) && m_tready;
            end
        end
    end

    assign m_tvalid  = active && g_vld;
    assign m_tlast   = active && g_last;
    assign m_tdata   = g_dat;
    assign m_tkeep   = g_keep;
    assign m_tuser   = g_user;
    assign m_tid     = {grant_q, g_tid};
    assign frame_end = m_tvalid && m_tready && m_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= PORT_W'(PORTS-1);
            stat_grant_q <= '0;
        end else begin
            stat_grant_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        grant_q      <= sel_idx;
                        rr_ptr_q     <= sel_idx;
                        stat_grant_q <= PORTS'(1) << sel_idx;
                        state_q      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (frame_end) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stat_grant = rst ? '0 : stat_grant_q;
    assign stat_busy  = active;

    // Completions whose port field names no source are acked and discarded.
    assign cpl_port = s_cpl_tid[MAC_TAG_W-1:SRC_TAG_W];

    always_comb begin
        m_cpl_tvalid = '0;
        cpl_rdy      = 1'b1;
        for (int i = 0; i < PORTS; i++) begin
            if (cpl_port == PORT_W'(i)) begin
                m_cpl_tvalid[i] = s_cpl_tvalid && !rst;
                cpl_rdy         = m_cpl_tready[i];
            end
        end
    end

    assign s_cpl_tready = cpl_rdy && !rst;
    assign m_cpl_tdata  = s_cpl_tdata;
    assign m_cpl_tid    = s_cpl_tid[SRC_TAG_W-1:0];

endmodule

// File: tb/tb_taxi_eth_tx_frame_arb.sv
// Scoreboard bench for taxi_eth_tx_frame_arb (PORTS=4 main instance, PORTS=3 instance for tag drop).
module tb_taxi_eth_tx_frame_arb;

    localparam int P   = 4;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int TW  = 12;
    localparam int MTW = 14;
    localparam int CW  = 96;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
        logic [TW-1:0] t;
    } beat_t;

    typedef struct {
        logic [P-1:0]  vld;
        logic [TW-1:0] tid;
        logic [CW-1:0] dat;
    } cpl_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [P*DW-1:0]  s_tdata;
    logic [P*KW-1:0]  s_tkeep;
    logic [P-1:0]     s_tvalid, s_tready, s_tlast, s_tuser;
    logic [P*TW-1:0]  s_tid;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tvalid, m_tready, m_tlast;
    logic [0:0]       m_tuser;
    logic [MTW-1:0]   m_tid;
    logic [CW-1:0]    s_cpl_tdata, m_cpl_tdata;
    logic [MTW-1:0]   s_cpl_tid;
    logic             s_cpl_tvalid, s_cpl_tready;
    logic [TW-1:0]    m_cpl_tid;
    logic [P-1:0]     m_cpl_tvalid, m_cpl_tready, cfg_port_enable, stat_grant;
    logic             stat_busy;

    logic [3*DW-1:0]  s_tdata3;
    logic [3*KW-1:0]  s_tkeep3;
    logic [2:0]       s_tvalid3, s_tready3, s_tlast3, s_tuser3;
    logic [3*TW-1:0]  s_tid3;
    logic [DW-1:0]    m_tdata3;
    logic [KW-1:0]    m_tkeep3;
    logic             m_tvalid3, m_tlast3;
    logic [0:0]       m_tuser3;
    logic [MTW-1:0]   m_tid3;
    logic [CW-1:0]    m_cpl_tdata3;
    logic [MTW-1:0]   s_cpl_tid3;
    logic             s_cpl_tvalid3, s_cpl_tready3;
    logic [TW-1:0]    m_cpl_tid3;
    logic [2:0]       m_cpl_tvalid3, m_cpl_tready3, stat_grant3;
    logic             stat_busy3;

    taxi_eth_tx_frame_arb #(.PORTS(P)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tid(s_tid),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid),
        .s_cpl_tdata(s_cpl_tdata), .s_cpl_tid(s_cpl_tid), .s_cpl_tvalid(s_cpl_tvalid),
        .s_cpl_tready(s_cpl_tready),
        .m_cpl_tdata(m_cpl_tdata), .m_cpl_tid(m_cpl_tid), .m_cpl_tvalid(m_cpl_tvalid),
        .m_cpl_tready(m_cpl_tready),
        .cfg_port_enable(cfg_port_enable), .stat_grant(stat_grant), .stat_busy(stat_busy)
    );

    taxi_eth_tx_frame_arb #(.PORTS(3)) dut3 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata3), .s_tkeep(s_tkeep3), .s_tvalid(s_tvalid3), .s_tready(s_tready3),
        .s_tlast(s_tlast3), .s_tuser(s_tuser3), .s_tid(s_tid3),
        .m_tdata(m_tdata3), .m_tkeep(m_tkeep3), .m_tvalid(m_tvalid3), .m_tready(1'b1),
        .m_tlast(m_tlast3), .m_tuser(m_tuser3), .m_tid(m_tid3),
        .s_cpl_tdata(s_cpl_tdata), .s_cpl_tid(s_cpl_tid3), .s_cpl_tvalid(s_cpl_tvalid3),
        .s_cpl_tready(s_cpl_tready3),
        .m_cpl_tdata(m_cpl_tdata3), .m_cpl_tid(m_cpl_tid3), .m_cpl_tvalid(m_cpl_tvalid3),
        .m_cpl_tready(m_cpl_tready3),
        .cfg_port_enable(3'b111), .stat_grant(stat_grant3), .stat_busy(stat_busy3)
    );

    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    beat_t src_q [P][$];
    beat_t exp_q [P][$];
    int    exp_gnt[$];
    cpl_t  exp_cpl[$];
    int    fired  [P];
    int    gcount [P];
    bit    bp_en      = 1'b0;
    bit    chk_bubble = 1'b0;
    bit    have_end   = 1'b0;
    int    last_end   = 0;
    int    cur        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string nm, input int waited);
        n_chk++;
        n_fail++;
        $display("FAIL timeout %s: waited %0d cycles, condition never reached", nm, waited);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input int p, input int n, input logic [TW-1:0] tid, input bit rnd);
        beat_t b;
        for (int j = 0; j < n; j++) begin
            b.d = rnd ? {$urandom, $urandom} : {8'(p), tid, 12'(j), 32'(32'hC0DE_0000 + j)};
            b.k = (rnd && j == n-1) ? 8'h0F : 8'hFF;
            b.l = (j == n-1);
            b.u = (j == n-1) && tid[0];
            b.t = tid;
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    function automatic bit all_drained();
        for (int p = 0; p < P; p++) begin
            if (exp_q[p].size() != 0) return 1'b0;
        end
        return exp_gnt.size() == 0;
    endfunction

    task automatic wait_drain(input int bound, input string nm);
        int t = 0;
        while (!all_drained() && t < bound) begin
            tick();
            t++;
        end
        if (!all_drained()) timeout_fail(nm, t);
    endtask

    // Source models: advance on an observed handshake, present the queue head.
    initial begin : driver
        bit    fire [P];
        beat_t b;
        s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0; s_tid = '0;
        foreach (fired[i]) fired[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < P; i++) fire[i] = s_tvalid[i] && s_tready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < P; i++) begin
                if (fire[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    fired[i]++;
                end
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    s_tvalid[i]          = 1'b1;
                    s_tdata[i*DW +: DW]  = b.d;
                    s_tkeep[i*KW +: KW]  = b.k;
                    s_tlast[i]           = b.l;
                    s_tuser[i]           = b.u;
                    s_tid[i*TW +: TW]    = b.t;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
            if (bp_en) m_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : monitor
        beat_t b;
        cpl_t  c;
        int    g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stat_grant != '0) begin
                    if (exp_gnt.size() == 0) begin
                        chk("grant_unexpected", 128'(stat_grant), 128'(0));
                    end else begin
                        g = exp_gnt.pop_front();
                        chk("stat_grant", 128'(stat_grant), 128'(4'(1) << g));
                        cur = g;
                        gcount[g]++;
                        if (chk_bubble && have_end) chk("grant_gap", 128'(cyc - last_end), 128'(2));
                    end
                end
                if (stat_busy) begin
                    chk("s_tready_other", 128'(s_tready & ~(4'(1) << cur)), 128'(0));
                    chk("s_tready_gnt", 128'(s_tready[cur]), 128'(m_tready));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q[cur].size() == 0) begin
                        chk("beat_unexpected", 128'(m_tdata), 128'(0));
                    end else begin
                        b = exp_q[cur].pop_front();
                        chk("m_tdata", 128'(m_tdata), 128'(b.d));
                        chk("m_tkeep", 128'(m_tkeep), 128'(b.k));
                        chk("m_tlast", 128'(m_tlast), 128'(b.l));
                        chk("m_tuser", 128'(m_tuser), 128'(b.u));
                        chk("m_tid", 128'(m_tid), 128'({2'(cur), b.t}));
                        if (m_tlast) begin
                            last_end = cyc;
                            have_end = 1'b1;
                        end
                    end
                end
                if (s_cpl_tvalid && s_cpl_tready) begin
                    if (exp_cpl.size() == 0) begin
                        chk("cpl_unexpected", 128'(s_cpl_tid), 128'(0));
                    end else begin
                        c = exp_cpl.pop_front();
                        chk("m_cpl_tvalid", 128'(m_cpl_tvalid), 128'(c.vld));
                        chk("m_cpl_tid", 128'(m_cpl_tid), 128'(c.tid));
                        chk("m_cpl_tdata", 128'(m_cpl_tdata), 128'(c.dat));
                    end
                end
            end
        end
    end

    initial begin : main
        int t;
        int base;
        rst = 1'b1;
        m_tready = 1'b1;
        cfg_port_enable = 4'hF;
        s_cpl_tvalid = 1'b1;
        s_cpl_tid = {2'd0, 12'h001};
        s_cpl_tdata = 96'h55;
        m_cpl_tready = 4'hF;
        s_tdata3 = '0; s_tkeep3 = '0; s_tvalid3 = '0; s_tlast3 = '0; s_tuser3 = '0; s_tid3 = '0;
        s_cpl_tid3 = '0; s_cpl_tvalid3 = 1'b0; m_cpl_tready3 = 3'b111;
        foreach (gcount[i]) gcount[i] = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 128'(s_tready), 128'(0));
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_m_tlast", 128'(m_tlast), 128'(0));
        chk("rst_m_cpl_tvalid", 128'(m_cpl_tvalid), 128'(0));
        chk("rst_s_cpl_tready", 128'(s_cpl_tready), 128'(0));
        chk("rst_stat_grant", 128'(stat_grant), 128'(0));
        chk("rst_stat_busy", 128'(stat_busy), 128'(0));
        tick();
        s_cpl_tvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 128'(stat_busy), 128'(0));
        chk("post_rst_m_tvalid", 128'(m_tvalid), 128'(0));

        // Source 0 alone, two 8-beat frames: grant gap of one idle cycle.
        chk_bubble = 1'b1;
        have_end = 1'b0;
        exp_gnt.push_back(0);
        exp_gnt.push_back(0);
        send_frame(0, 8, 12'h005, 1'b0);
        send_frame(0, 8, 12'h005, 1'b0);
        wait_drain(200, "single_source");
        chk_bubble = 1'b0;

        // All four continuously valid; last grant was 0 so order is 1,2,3,0.
        foreach (gcount[i]) gcount[i] = 0;
        for (int f = 0; f < 25; f++) begin
            for (int k = 1; k <= 4; k++) exp_gnt.push_back(k % 4);
            for (int p = 0; p < P; p++) send_frame(p, 3, 12'(16*f + p), 1'b0);
        end
        wait_drain(2000, "fairness");
        for (int p = 0; p < P; p++) chk("fair_count", 128'(gcount[p]), 128'(25));

        // Source 2 masked: 1,3,0,1,3,0 then 2,2 once re-enabled.
        cfg_port_enable = 4'b1011;
        foreach (exp_gnt[i]) ;
        exp_gnt.push_back(1); exp_gnt.push_back(3); exp_gnt.push_back(0);
        exp_gnt.push_back(1); exp_gnt.push_back(3); exp_gnt.push_back(0);
        exp_gnt.push_back(2); exp_gnt.push_back(2);
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < P; p++) send_frame(p, 3, 12'(12'h300 + 16*f + p), 1'b0);
        end
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[3].size()) != 0 && t < 500) begin
            tick();
            t++;
        end
        if ((exp_q[0].size() + exp_q[1].size() + exp_q[3].size()) != 0) timeout_fail("mask", t);
        chk("mask_src2_pending", 128'(exp_q[2].size()), 128'(6));
        tick();
        cfg_port_enable = 4'hF;
        wait_drain(200, "mask_reenable");

        // Disable source 0 mid-frame: frame completes, next frame waits for re-enable.
        exp_gnt.push_back(0);
        exp_gnt.push_back(0);
        base = fired[0];
        send_frame(0, 8, 12'h0A1, 1'b0);
        send_frame(0, 8, 12'h0A2, 1'b0);
        t = 0;
        while (fired[0] < base + 2 && t < 100) begin tick(); t++; end
        if (fired[0] < base + 2) timeout_fail("midframe_start", t);
        cfg_port_enable = 4'b1110;
        t = 0;
        while (exp_q[0].size() > 8 && t < 100) begin tick(); t++; end
        if (exp_q[0].size() > 8) timeout_fail("midframe_finish", t);
        repeat (6) tick();
        chk("disabled_idle", 128'(stat_busy), 128'(0));
        chk("disabled_pending", 128'(exp_q[0].size()), 128'(8));
        cfg_port_enable = 4'hF;
        wait_drain(200, "midframe_reenable");

        // Random backpressure on frames from sources 1 and 2.
        exp_gnt.push_back(1);
        exp_gnt.push_back(2);
        bp_en = 1'b1;
        send_frame(1, 6, 12'h1B1, 1'b1);
        send_frame(2, 6, 12'h2B2, 1'b1);
        wait_drain(500, "backpressure");
        bp_en = 1'b0;
        tick();
        m_tready = 1'b1;

        // Completion routing to source 3, held while its ready is low.
        exp_cpl.push_back('{vld: 4'b1000, tid: 12'hABC, dat: 96'h1234});
        s_cpl_tid = {2'd3, 12'hABC};
        s_cpl_tdata = 96'h1234;
        m_cpl_tready = 4'b0111;
        s_cpl_tvalid = 1'b1;
        @(negedge clk);
        chk("cpl_hold_ready", 128'(s_cpl_tready), 128'(0));
        chk("cpl_hold_vld", 128'(m_cpl_tvalid), 128'(4'b1000));
        tick();
        @(negedge clk);
        chk("cpl_hold_ready2", 128'(s_cpl_tready), 128'(0));
        chk("cpl_hold_tid", 128'(m_cpl_tid), 128'(12'hABC));
        tick();
        m_cpl_tready = 4'hF;
        tick();
        exp_cpl.push_back('{vld: 4'b0010, tid: 12'h077, dat: 96'hFEED});
        s_cpl_tid = {2'd1, 12'h077};
        s_cpl_tdata = 96'hFEED;
        tick();
        s_cpl_tvalid = 1'b0;

        // Three-port instance: port field 3 names no source and is dropped.
        s_cpl_tid3 = {2'd3, 12'h123};
        s_cpl_tvalid3 = 1'b1;
        @(negedge clk);
        chk("drop_ready", 128'(s_cpl_tready3), 128'(1));
        chk("drop_vld", 128'(m_cpl_tvalid3), 128'(0));
        tick();
        s_cpl_tid3 = {2'd2, 12'h456};
        m_cpl_tready3 = 3'b011;
        @(negedge clk);
        chk("p3_port2_ready", 128'(s_cpl_tready3), 128'(0));
        chk("p3_port2_vld", 128'(m_cpl_tvalid3), 128'(3'b100));
        chk("p3_port2_tid", 128'(m_cpl_tid3), 128'(12'h456));
        tick();
        s_cpl_tvalid3 = 1'b0;

        // Reset on beat 4 of a source 1 frame, then pointer restarts at PORTS-1.
        exp_gnt.push_back(1);
        base = fired[1];
        send_frame(1, 8, 12'h0C1, 1'b0);
        t = 0;
        while (fired[1] < base + 4 && t < 100) begin tick(); t++; end
        if (fired[1] < base + 4) timeout_fail("reset_mid", t);
        rst = 1'b1;
        src_q[1].delete();
        exp_q[1].delete();
        @(negedge clk);
        chk("midrst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("midrst_s_tready", 128'(s_tready), 128'(0));
        chk("midrst_busy", 128'(stat_busy), 128'(0));
        tick();
        tick();
        rst = 1'b0;
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        send_frame(0, 3, 12'h0D0, 1'b0);
        send_frame(1, 3, 12'h0D1, 1'b0);
        wait_drain(200, "after_reset");

        chk("gnt_drained", 128'(exp_gnt.size()), 128'(0));
        chk("cpl_drained", 128'(exp_cpl.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
